// File: rtl/lsu_dmem_master_if.sv
// Bundle of the LSU's pipeline-side request/response handshake and its
// data-memory port.
//   master modport : the LSU (drives req_ready, resp_*, mem_* outputs)
//   slave  modport : the surrounding pipeline plus data memory
// Signals:
//   req_valid/req_ready, req_write, req_funct3, req_addr, req_wdata : request
//   resp_valid/resp_ready, resp_rdata, resp_cause                    : response
//   mem_addr, mem_write, mem_type, mem_wdata, mem_rdata              : memory
interface lsu_dmem_master_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_cause;
    logic [XLEN-1:0] mem_addr;
    logic            mem_write;
    logic [2:0]      mem_type;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_cause,
        output mem_addr, mem_write, mem_type, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_cause,
        input  mem_addr, mem_write, mem_type, mem_wdata
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit: takes one RV32I load/store at a time from the pipeline,
// drives the data memory for exactly one cycle, sign/zero-extends load data
// and traps misaligned or illegal requests without touching memory.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : lsu_dmem_master_if.master (request, response and memory signals)
module lsu_dmem_master #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    lsu_dmem_master_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_OK      = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    state_t          state_r;
    state_t          state_next_s;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [2:0]      mem_type_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic            resp_valid_r;
    logic [XLEN-1:0] resp_rdata_r;
    logic [1:0]      resp_cause_r;
    logic            req_err_s;
    logic [1:0]      req_cause_s;

    // Reserved encodings, and unsigned variants which have no store form.
    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        logic ill;
        case (f3)
            3'b011, 3'b110, 3'b111: ill = 1'b1;
            default:                ill = wr & f3[2];
        endcase
        return ill;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Memory returns the field right-justified and zero-filled; only sign
    // extension needs work here.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Classify the incoming request; illegal wins over misaligned.
    always_comb begin
        req_cause_s = CAUSE_OK;
        if (is_illegal(bus.req_write, bus.req_funct3)) begin
            req_cause_s = CAUSE_ILLEGAL;
        end else if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
            req_cause_s = CAUSE_MISALGN;
        end else begin
            req_cause_s = CAUSE_OK;
        end
        req_err_s = (req_cause_s != CAUSE_OK);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next_s = req_err_s ? RESP : ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: state_next_s = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_r      <= 1'b0;
            funct3_r     <= 3'b000;
            mem_type_r   <= 3'b000;
            addr_r       <= {XLEN{1'b0}};
            wdata_r      <= {XLEN{1'b0}};
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_cause_r <= CAUSE_OK;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_r    <= bus.req_write;
                        funct3_r   <= bus.req_funct3;
                        mem_type_r <= {1'b0, bus.req_funct3[1:0]};
                        addr_r     <= bus.req_addr;
                        wdata_r    <= bus.req_wdata;
                        if (req_err_s) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= {XLEN{1'b0}};
                            resp_cause_r <= req_cause_s;
                        end
                    end
                end
                ACCESS: begin
                    resp_valid_r <= 1'b1;
                    resp_cause_r <= CAUSE_OK;
                    resp_rdata_r <= write_r ? {XLEN{1'b0}}
                                            : extend_load(funct3_r, bus.mem_rdata);
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end
                end
                default: resp_valid_r <= 1'b0;
            endcase
        end
    end

    // Reset gates these combinationally so a store caught mid-access never commits.
    assign bus.req_ready  = (state_r == IDLE) && !reset;
    assign bus.mem_write  = (state_r == ACCESS) && write_r && !reset;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_type   = mem_type_r;
    assign bus.mem_wdata  = wdata_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_cause = resp_cause_r;

endmodule

// File: tb/tb_lsu_dmem_master.sv
module tb_lsu_dmem_master;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   mem_writes;

    lsu_dmem_master_if #(.XLEN(32)) bus ();

    lsu_dmem_master #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory, 256 bytes, address wraps on [7:0].
    bit   [7:0] mem [256];
    logic [7:0] ma;
    logic [31:0] mword;
    assign ma = bus.mem_addr[7:0];

    always_comb begin
        mword = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        case (bus.mem_type[1:0])
            2'b00:   bus.mem_rdata = {24'd0, mword[7:0]};
            2'b01:   bus.mem_rdata = {16'd0, mword[15:0]};
            default: bus.mem_rdata = mword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.mem_write) begin
            mem_writes <= mem_writes + 1;
            mem[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_type[1:0] != 2'b00) mem[ma + 8'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_type[1:0] == 2'b10) begin
                mem[ma + 8'd2] <= bus.mem_wdata[23:16];
                mem[ma + 8'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_cause;
        int          exp_lat;
        int          exp_writes;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] er,
                                input logic [1:0] ec, input string name);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_cause = ec; v.name = name;
        v.exp_lat    = (ec == 2'b00) ? 2 : 1;
        v.exp_writes = (ec == 2'b00 && wr) ? 1 : 0;
        vecs.push_back(v);
    endfunction

    // Present a request (called at posedge+1) and return at posedge+1 after acceptance.
    task automatic accept(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name);
        logic ok;
        ok = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({name, " accept"}, {31'd0, ok}, 32'd1);
    endtask

    // Count cycles after acceptance until resp_valid; checks memory drive on the first.
    task automatic wait_resp(input vec_t v, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && v.exp_cause == 2'b00) begin
                check({v.name, " mem_addr"}, bus.mem_addr, v.addr);
                check({v.name, " mem_type"}, {29'd0, bus.mem_type}, {29'd0, 1'b0, v.f3[1:0]});
                check({v.name, " mem_write"}, {31'd0, bus.mem_write}, {31'd0, v.wr});
                if (v.wr) check({v.name, " mem_wdata"}, bus.mem_wdata, v.wdata);
            end
            if (bus.resp_valid) break;
        end
    endtask

    task automatic release_resp(input string name);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({name, " resp_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    task automatic do_req(input vec_t v);
        int w0;
        int lat;
        w0 = mem_writes;
        accept(v.wr, v.f3, v.addr, v.wdata, v.name);
        wait_resp(v, lat);
        check({v.name, " latency"}, lat, v.exp_lat);
        check({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
        check({v.name, " cause"}, {30'd0, bus.resp_cause}, {30'd0, v.exp_cause});
        check({v.name, " writes"}, mem_writes - w0, v.exp_writes);
        release_resp(v.name);
    endtask

    initial begin
        int          w0;
        int          lat;
        logic [31:0] hold_rdata;
        logic [1:0]  hold_cause;
        vec_t        v;

        n_checks = 0; n_fail = 0; mem_writes = 0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;

        // Memory word 0x20 = 0x80FF7F01 -> bytes 01, 7F, FF, 80 (little-endian).
        add(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, "sw_10");
        add(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, "lw_10");
        add(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 2'b00, "sw_20");
        add(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 2'b00, "lb_23");
        add(1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 2'b00, "lbu_23");
        add(1'b0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 2'b00, "lb_21");
        add(1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFFF, 2'b00, "lb_22");
        add(1'b0, 3'b000, 32'h20, 32'h0, 32'h00000001, 2'b00, "lb_20");
        add(1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 2'b00, "sw_30");
        add(1'b1, 3'b001, 32'h32, 32'hFFFFABCD, 32'h0, 2'b00, "sh_32");
        add(1'b0, 3'b010, 32'h30, 32'h0, 32'hABCD1111, 2'b00, "lw_30");
        add(1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFFABCD, 2'b00, "lh_32");
        add(1'b0, 3'b101, 32'h32, 32'h0, 32'h0000ABCD, 2'b00, "lhu_32");
        add(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 2'b01, "lw_42_mis");
        add(1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 2'b10, "sb_f3_100_ill");
        add(1'b0, 3'b011, 32'h43, 32'h0, 32'h0, 2'b10, "f3_011_mis_ill");
        add(1'b1, 3'b010, 32'h12, 32'h77, 32'h0, 2'b01, "sw_12_mis");
        add(1'b0, 3'b001, 32'h33, 32'h0, 32'h0, 2'b01, "lh_33_mis");
        add(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 2'b10, "f3_110_ill");
        add(1'b1, 3'b010, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0, 2'b00, "sw_wrap");
        add(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'hCAFEF00D, 2'b00, "lw_wrap");
        add(1'b1, 3'b010, 32'h50, 32'h0BADF00D, 32'h0, 2'b00, "sw_50");

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_cause", {30'd0, bus.resp_cause}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_type", {29'd0, bus.mem_type}, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // Backpressure: response held for 5 cycles, extra requests ignored.
        v = vecs[1];
        v.name = "bp_lw";
        w0 = mem_writes;
        accept(v.wr, v.f3, v.addr, v.wdata, v.name);
        wait_resp(v, lat);
        check("bp latency", lat, 2);
        hold_rdata = bus.resp_rdata;
        hold_cause = bus.resp_cause;
        check("bp rdata", hold_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
            bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
            @(negedge clk);
            check("bp resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("bp req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp rdata_stable", bus.resp_rdata, 32'hDEADBEEF);
            check("bp cause_stable", {30'd0, bus.resp_cause}, 32'd0);
            bus.req_valid = 1'b0;
        end
        check("bp writes", mem_writes - w0, 0);
        release_resp("bp");
        v.name = "bp_lw_after";
        do_req(v);

        // Reset during the access cycle of a store: nothing committed.
        w0 = mem_writes;
        accept(1'b1, 3'b010, 32'h50, 32'h12345678, "rst_sw");
        reset = 1'b1;
        #1;
        check("rst_sw mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_sw req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_sw writes", mem_writes - w0, 0);
        check("rst_sw resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_sw resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_sw resp_cause", {30'd0, bus.resp_cause}, 32'd0);
        check("rst_sw mem_addr", bus.mem_addr, 32'd0);
        check("rst_sw mem_type", {29'd0, bus.mem_type}, 32'd0);
        check("rst_sw mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sw req_ready_after", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        v = vecs[1];
        v.addr = 32'h50; v.exp_rdata = 32'h0BADF00D; v.name = "lw_50_after_rst";
        do_req(v);

        // Reset during RESP drops the response.
        v = vecs[1];
        v.name = "rst_resp";
        accept(v.wr, v.f3, v.addr, v.wdata, v.name);
        wait_resp(v, lat);
        check("rst_resp valid_before", {31'd0, bus.resp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_resp dropped", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp req_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
